// File: rtl/riscv_pkg.sv
// Shared core constants and the writeback request record used by the
// load-return buffer and the register-file write port.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback requests; head is visible while not empty.
// push is ignored when full, pop is ignored when empty.
module wb_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    n_rst,
  input  logic    push,
  input  wb_req_t din,
  input  logic    pop,
  output wb_req_t head,
  output logic    full,
  output logic    empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_req_t            mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write port arbiter: ALU results win, load returns queue in a
// FIFO; a busy-bit scoreboard of outstanding loads drives decode stall.
module writeback_arbiter
  import riscv_pkg::*;
#(
  parameter int LD_FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  ld_issue,
  input  logic [REG_ADDR_W-1:0] ld_issue_rd,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [XLEN-1:0]       ld_data,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  stall,
  output logic                  RegWr,
  output logic [REG_ADDR_W-1:0] write_reg,
  output logic [XLEN-1:0]       write_data,
  output logic                  waw_err
);

  // Load handshake: a beat transfers on a cycle where ld_valid && ld_ready;
  // ld_ready depends only on registered FIFO occupancy, never on ld_valid.
  wb_req_t               fifo_din;
  wb_req_t               fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  alu_win;
  logic                  wb_is_load;
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_next;

  assign ld_ready  = !fifo_full;
  assign fifo_din  = '{rd: ld_rd, data: ld_data};
  // Loads to x0 complete the handshake but are dropped here.
  assign fifo_push = ld_valid && ld_ready && (ld_rd != '0);
  assign alu_win   = alu_valid && (alu_rd != '0);
  assign fifo_pop  = !alu_win && !fifo_empty;

  wb_fifo #(.DEPTH(LD_FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      RegWr      <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
      wb_is_load <= 1'b0;
    end else if (alu_win) begin
      RegWr      <= 1'b1;
      write_reg  <= alu_rd;
      write_data <= alu_data;
      wb_is_load <= 1'b0;
    end else if (fifo_pop) begin
      RegWr      <= 1'b1;
      write_reg  <= fifo_head.rd;
      write_data <= fifo_head.data;
      wb_is_load <= 1'b1;
    end else begin
      RegWr      <= 1'b0;
      wb_is_load <= 1'b0;
    end
  end

  // Clear lands on the same edge the register file commits the load; a
  // same-edge issue to that register is a newer load, so set is applied last.
  always_comb begin
    busy_next = busy;
    if (RegWr && wb_is_load) busy_next[write_reg] = 1'b0;
    if (ld_issue && (ld_issue_rd != '0)) busy_next[ld_issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      busy    <= '0;
      waw_err <= 1'b0;
    end else begin
      busy <= busy_next;
      if (alu_win && busy[alu_rd]) waw_err <= 1'b1;
    end
  end

  assign stall = ((rs1 != '0) && busy[rs1]) || ((rs2 != '0) && busy[rs2]);

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: reset, ALU path, load path, contention,
// scoreboard set/clear collision, WAW flag and asynchronous reset mid-occupancy.
module tb_writeback_arbiter;
  import riscv_pkg::*;

  logic                  clk;
  logic                  n_rst;
  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_data;
  logic                  ld_issue;
  logic [REG_ADDR_W-1:0] ld_issue_rd;
  logic                  ld_valid;
  logic                  ld_ready;
  logic [REG_ADDR_W-1:0] ld_rd;
  logic [XLEN-1:0]       ld_data;
  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;
  logic                  stall;
  logic                  RegWr;
  logic [REG_ADDR_W-1:0] write_reg;
  logic [XLEN-1:0]       write_data;
  logic                  waw_err;

  int tests_run;
  int tests_failed;

  writeback_arbiter #(.LD_FIFO_DEPTH(2)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .ld_issue    (ld_issue),
    .ld_issue_rd (ld_issue_rd),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_rd       (ld_rd),
    .ld_data     (ld_data),
    .rs1         (rs1),
    .rs2         (rs2),
    .stall       (stall),
    .RegWr       (RegWr),
    .write_reg   (write_reg),
    .write_data  (write_data),
    .waw_err     (waw_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic v, input logic [REG_ADDR_W-1:0] rd, input logic [XLEN-1:0] d);
    alu_valid = v;
    alu_rd    = rd;
    alu_data  = d;
  endtask

  task automatic drive_ld(input logic v, input logic [REG_ADDR_W-1:0] rd, input logic [XLEN-1:0] d);
    ld_valid = v;
    ld_rd    = rd;
    ld_data  = d;
  endtask

  task automatic issue(input logic v, input logic [REG_ADDR_W-1:0] rd);
    ld_issue    = v;
    ld_issue_rd = rd;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    n_rst = 1'b0;
    drive_alu(1'b0, '0, '0);
    issue(1'b0, '0);
    drive_ld(1'b1, 5'd3, 32'h0000_0033);
    rs1 = 5'd3;
    rs2 = 5'd0;

    // 1. reset held with ld_valid asserted
    tick(); tick();
    check("rst_regwr",   32'(RegWr), 0);
    check("rst_ready",   32'(ld_ready), 1);
    check("rst_stall",   32'(stall), 0);
    check("rst_waw",     32'(waw_err), 0);
    check("rst_wreg",    32'(write_reg), 0);
    check("rst_wdata",   write_data, 0);
    drive_ld(1'b0, '0, '0);
    n_rst = 1'b1;
    tick(); tick(); tick();
    check("idle_regwr",  32'(RegWr), 0);

    // 2. ALU only
    drive_alu(1'b1, 5'd5, 32'hDEAD_BEEF);
    tick();
    drive_alu(1'b1, 5'd0, 32'h0000_0055);
    check("alu_regwr",   32'(RegWr), 1);
    check("alu_wreg",    32'(write_reg), 5);
    check("alu_wdata",   write_data, 32'hDEAD_BEEF);
    tick();
    drive_alu(1'b0, '0, '0);
    check("alu_x0_regwr", 32'(RegWr), 0);
    check("alu_x0_hreg",  32'(write_reg), 5);
    check("alu_x0_hdata", write_data, 32'hDEAD_BEEF);

    // 3. load path
    rs1 = 5'd7;
    issue(1'b1, 5'd7);
    tick();
    issue(1'b0, '0);
    check("ld_stall_set", 32'(stall), 1);
    tick(); tick();
    check("ld_stall_wait", 32'(stall), 1);
    drive_ld(1'b1, 5'd7, 32'h0000_1234);
    #1;
    check("ld_ready_m",  32'(ld_ready), 1);
    tick();
    drive_ld(1'b0, '0, '0);
    check("ld_m1_regwr", 32'(RegWr), 0);
    tick();
    check("ld_m2_regwr", 32'(RegWr), 1);
    check("ld_m2_wreg",  32'(write_reg), 7);
    check("ld_m2_wdata", write_data, 32'h0000_1234);
    check("ld_m2_stall", 32'(stall), 1);
    tick();
    check("ld_m3_stall", 32'(stall), 0);
    check("ld_m3_regwr", 32'(RegWr), 0);

    // 4. contention: ALU every cycle N..N+3, loads 1,2,3 back-to-back
    for (int i = 1; i <= 3; i++) begin
      issue(1'b1, REG_ADDR_W'(i));
      tick();
    end
    issue(1'b0, '0);
    rs1 = 5'd1;
    rs2 = 5'd0;
    drive_alu(1'b1, 5'd10, 32'h0000_00A0);
    drive_ld(1'b1, 5'd1, 32'h0000_0111);
    #1;
    check("ct_n_ready", 32'(ld_ready), 1);
    tick();
    drive_alu(1'b1, 5'd11, 32'h0000_00A1);
    drive_ld(1'b1, 5'd2, 32'h0000_0222);
    check("ct_n1_ready", 32'(ld_ready), 1);
    check("ct_n1_wreg",  32'(write_reg), 10);
    tick();
    drive_alu(1'b1, 5'd12, 32'h0000_00A2);
    drive_ld(1'b1, 5'd3, 32'h0000_0333);
    check("ct_n2_ready", 32'(ld_ready), 0);
    tick();
    drive_alu(1'b1, 5'd13, 32'h0000_00A3);
    check("ct_n3_ready", 32'(ld_ready), 0);
    check("ct_n3_wreg",  32'(write_reg), 12);
    tick();
    drive_alu(1'b0, '0, '0);
    check("ct_n4_ready", 32'(ld_ready), 0);
    check("ct_n4_wreg",  32'(write_reg), 13);
    check("ct_n4_wdata", write_data, 32'h0000_00A3);
    tick();
    check("ct_n5_ready", 32'(ld_ready), 1);
    check("ct_n5_regwr", 32'(RegWr), 1);
    check("ct_n5_wreg",  32'(write_reg), 1);
    check("ct_n5_wdata", write_data, 32'h0000_0111);
    check("ct_n5_stall", 32'(stall), 1);
    tick();
    drive_ld(1'b0, '0, '0);
    check("ct_n6_wreg",  32'(write_reg), 2);
    check("ct_n6_wdata", write_data, 32'h0000_0222);
    check("ct_n6_stall", 32'(stall), 0);
    tick();
    check("ct_n7_regwr", 32'(RegWr), 1);
    check("ct_n7_wreg",  32'(write_reg), 3);
    check("ct_n7_wdata", write_data, 32'h0000_0333);
    tick();
    rs1 = 5'd3;
    #1;
    check("ct_n8_regwr", 32'(RegWr), 0);
    check("ct_n8_stall", 32'(stall), 0);
    check("ct_waw_clean", 32'(waw_err), 0);

    // 5. set/clear collision on rd=9
    rs1 = 5'd0;
    issue(1'b1, 5'd9);
    tick();
    issue(1'b0, '0);
    drive_ld(1'b1, 5'd9, 32'h0000_0099);
    tick();
    drive_ld(1'b0, '0, '0);
    tick();
    check("col_regwr", 32'(RegWr), 1);
    check("col_wreg",  32'(write_reg), 9);
    issue(1'b1, 5'd9);
    rs2 = 5'd9;
    tick();
    issue(1'b0, '0);
    check("col_stall", 32'(stall), 1);
    tick();
    check("col_stall_hold", 32'(stall), 1);

    // load returning to x0 is accepted but never written
    rs2 = 5'd0;
    drive_ld(1'b1, 5'd0, 32'h0000_0F0F);
    #1;
    check("x0_ready", 32'(ld_ready), 1);
    tick();
    drive_ld(1'b0, '0, '0);
    tick();
    check("x0_m2_regwr", 32'(RegWr), 0);

    // 6. WAW flag, then async reset with FIFO occupied
    issue(1'b1, 5'd4);
    tick();
    issue(1'b0, '0);
    drive_alu(1'b1, 5'd4, 32'h0000_4444);
    tick();
    check("waw_flag",  32'(waw_err), 1);
    check("waw_regwr", 32'(RegWr), 1);
    check("waw_wreg",  32'(write_reg), 4);
    check("waw_wdata", write_data, 32'h0000_4444);
    drive_alu(1'b1, 5'd20, 32'h0000_2020);
    drive_ld(1'b1, 5'd4, 32'h0000_0404);
    tick(); tick();
    drive_ld(1'b0, '0, '0);
    rs1 = 5'd4;
    check("occ_ready", 32'(ld_ready), 0);
    check("occ_waw",   32'(waw_err), 1);
    #2;
    n_rst = 1'b0;
    #1;
    check("arst_ready", 32'(ld_ready), 1);
    check("arst_waw",   32'(waw_err), 0);
    check("arst_regwr", 32'(RegWr), 0);
    check("arst_wreg",  32'(write_reg), 0);
    check("arst_stall", 32'(stall), 0);
    drive_alu(1'b0, '0, '0);
    tick();
    n_rst = 1'b1;
    tick(); tick(); tick();
    check("post_regwr", 32'(RegWr), 0);
    check("post_stall", 32'(stall), 0);
    check("post_ready", 32'(ld_ready), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
